// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
// Shared definitions for the fetch/control front end of the 9-bit core:
//   - ALU command codes driven on ALUOp
//   - instruction group codes (mach_code[8:7]) and R-type sub-ops (mach_code[6:4])
//   - the 16-entry branch-target table (entry k holds 4*k)
//   - ctrl_t, the bundle of decoder outputs, and its default value
package fetch_ctrl_pkg;

    // ALU commands
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_LSL = 4'b0100;
    localparam logic [3:0] ALU_LSR = 4'b0101;

    // Instruction groups, mach_code[8:7]
    localparam logic [1:0] GRP_R    = 2'b00;
    localparam logic [1:0] GRP_MOVI = 2'b01;
    localparam logic [1:0] GRP_LB   = 2'b10;
    localparam logic [1:0] GRP_SB   = 2'b11;

    // R-type sub-ops, mach_code[6:4]
    localparam logic [2:0] SUB_ADD  = 3'b000;
    localparam logic [2:0] SUB_SUB  = 3'b001;
    localparam logic [2:0] SUB_AND  = 3'b010;
    localparam logic [2:0] SUB_XOR  = 3'b011;
    localparam logic [2:0] SUB_LSL  = 3'b100;
    localparam logic [2:0] SUB_LSR  = 3'b101;
    localparam logic [2:0] SUB_ADDI = 3'b110;
    localparam logic [2:0] SUB_BR   = 3'b111;

    // Branch-target table: entry k = 4*k (12 bits, resized to the PC width by the user)
    localparam logic [11:0] LUT_TARGETS [16] = '{
        12'd0,  12'd4,  12'd8,  12'd12,
        12'd16, 12'd20, 12'd24, 12'd28,
        12'd32, 12'd36, 12'd40, 12'd44,
        12'd48, 12'd52, 12'd56, 12'd60
    };

    // Decoder output bundle
    typedef struct packed {
        logic [1:0] inst_type;   // bit1 = I-type register fields, bit0 = immediate write data
        logic       branch_inst;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;     // 1 = register B, 0 = immediate
        logic       reg_write;
        logic       mem_to_reg;
        logic [3:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{
        inst_type:   2'b00,
        branch_inst: 1'b0,
        mem_read:    1'b0,
        mem_write:   1'b0,
        alu_src:     1'b1,
        reg_write:   1'b0,
        mem_to_reg:  1'b0,
        alu_op:      ALU_ADD
    };

endpackage

// File: rtl/fetch_ctrl_decode.sv
// fetch_ctrl_decode
// Purely combinational main decoder. Zero latency, no clock or reset, so its
// outputs are valid at all times including while the PC is held in reset.
// Ports:
//   op_bits  in  5        mach_code[8:4]: group in [4:3], R-type sub-op in [2:0]
//   ctrl     out ctrl_t   decoded datapath controls
module fetch_ctrl_decode
    import fetch_ctrl_pkg::*;
(
    input  logic [4:0] op_bits,
    output ctrl_t      ctrl
);

    logic [1:0] grp;
    logic [2:0] sub_op;

    assign grp    = op_bits[4:3];
    assign sub_op = op_bits[2:0];

    always_comb begin
        ctrl = CTRL_DEFAULT;
        case (grp)
            GRP_MOVI: begin
                ctrl.inst_type = 2'b11;
                ctrl.reg_write = 1'b1;
            end
            GRP_LB: begin
                ctrl.inst_type  = 2'b10;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b0;
                ctrl.alu_op     = ALU_ADD;
            end
            GRP_SB: begin
                ctrl.inst_type = 2'b10;
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b0;
                ctrl.alu_op    = ALU_ADD;
            end
            default: begin
                // R-type: everything except BR writes the register file
                ctrl.inst_type = 2'b00;
                ctrl.reg_write = 1'b1;
                case (sub_op)
                    SUB_ADD:  ctrl.alu_op = ALU_ADD;
                    SUB_SUB:  ctrl.alu_op = ALU_SUB;
                    SUB_AND:  ctrl.alu_op = ALU_AND;
                    SUB_XOR:  ctrl.alu_op = ALU_XOR;
                    SUB_LSL:  ctrl.alu_op = ALU_LSL;
                    SUB_LSR:  ctrl.alu_op = ALU_LSR;
                    SUB_ADDI: begin
                        ctrl.alu_op  = ALU_ADD;
                        ctrl.alu_src = 1'b0;
                    end
                    default: begin
                        // BR compares via subtract; no register write
                        ctrl.alu_op      = ALU_SUB;
                        ctrl.branch_inst = 1'b1;
                        ctrl.reg_write   = 1'b0;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/fetch_ctrl_unit.sv
// fetch_ctrl_unit
// Front end of the 9-bit single-cycle core: program counter, 16-entry
// branch-target table and the main decoder (fetch_ctrl_decode).
// Optional macro REL_JUMP_EN: when defined, a taken BR with mach_code[3] = 1
// jumps PC-relative by sign-extended mach_code[2:0]; otherwise (and always
// when undefined) a taken branch loads the table target.
// Ports:
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous active-low reset (PC -> 0)
//   mach_code    in   9   current instruction from ROM
//   branch_cond  in   1   registered "one" flag from the ALU
//   prog_ctr     out  D   current PC
//   target       out  D   table target for mach_code[3:0]
//   InstType     out  2   bit1 = I-type register fields, bit0 = immediate data
//   BranchInst   out  1   branch instruction
//   MemRead      out  1   load
//   MemWrite     out  1   store
//   ALUSrc       out  1   1 = register B, 0 = immediate
//   RegWrite     out  1   register-file write enable
//   MemtoReg     out  1   memory data / rt write-address select
//   ALUOp        out  A   ALU command
//   done         out  1   prog_ctr == DONE_PC; PC freezes there
module fetch_ctrl_unit
    import fetch_ctrl_pkg::*;
#(
    parameter int D       = 12,
    parameter int A       = 4,
    parameter int DONE_PC = 50
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [8:0]   mach_code,
    input  logic         branch_cond,
    output logic [D-1:0] prog_ctr,
    output logic [D-1:0] target,
    output logic [1:0]   InstType,
    output logic         BranchInst,
    output logic         MemRead,
    output logic         MemWrite,
    output logic         ALUSrc,
    output logic         RegWrite,
    output logic         MemtoReg,
    output logic [A-1:0] ALUOp,
    output logic         done
);

    ctrl_t        ctrl;
    logic [D-1:0] prog_ctr_q;
    logic [D-1:0] prog_ctr_d;

    fetch_ctrl_decode u_decode (
        .op_bits (mach_code[8:4]),
        .ctrl    (ctrl)
    );

    assign InstType   = ctrl.inst_type;
    assign BranchInst = ctrl.branch_inst;
    assign MemRead    = ctrl.mem_read;
    assign MemWrite   = ctrl.mem_write;
    assign ALUSrc     = ctrl.alu_src;
    assign RegWrite   = ctrl.reg_write;
    assign MemtoReg   = ctrl.mem_to_reg;
    assign ALUOp      = A'(ctrl.alu_op);

    assign target   = D'(LUT_TARGETS[mach_code[3:0]]);
    assign prog_ctr = prog_ctr_q;
    assign done     = (prog_ctr_q == D'(DONE_PC));

`ifdef REL_JUMP_EN
    logic [D-1:0] rel_offset;
    assign rel_offset = {{(D-3){mach_code[2]}}, mach_code[2:0]};
`endif

    // Halt beats branch beats increment. Increment wraps naturally at 2^D.
    always_comb begin
        prog_ctr_d = prog_ctr_q + D'(1);
        if (done) begin
            prog_ctr_d = prog_ctr_q;
        end else if (ctrl.branch_inst && branch_cond) begin
`ifdef REL_JUMP_EN
            if (mach_code[3]) begin
                prog_ctr_d = prog_ctr_q + rel_offset;
            end else begin
                prog_ctr_d = target;
            end
`else
            prog_ctr_d = target;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prog_ctr_q <= '0;
        end else begin
            prog_ctr_q <= prog_ctr_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl_unit.sv
// tb_fetch_ctrl_unit
// Directed plus randomized stimulus for fetch_ctrl_unit, checked against a
// behavioural model of the decode table and PC rules.
// Honours macro REL_JUMP_EN the same way the design does.
module tb_fetch_ctrl_unit;

    logic        clk;
    logic        reset;
    logic [8:0]  mach_code;
    logic        branch_cond;
    logic [11:0] prog_ctr;
    logic [11:0] target;
    logic [1:0]  InstType;
    logic        BranchInst;
    logic        MemRead;
    logic        MemWrite;
    logic        ALUSrc;
    logic        RegWrite;
    logic        MemtoReg;
    logic [3:0]  ALUOp;
    logic        done;

    int checks   = 0;
    int failures = 0;
    int model_pc = 0;

    fetch_ctrl_unit #(.D(12), .A(4), .DONE_PC(50)) dut (
        .clk         (clk),
        .reset       (reset),
        .mach_code   (mach_code),
        .branch_cond (branch_cond),
        .prog_ctr    (prog_ctr),
        .target      (target),
        .InstType    (InstType),
        .BranchInst  (BranchInst),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .ALUSrc      (ALUSrc),
        .RegWrite    (RegWrite),
        .MemtoReg    (MemtoReg),
        .ALUOp       (ALUOp),
        .done        (done)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected controls packed as {InstType, BranchInst, MemRead, MemWrite,
    // ALUSrc, RegWrite, MemtoReg, ALUOp}, built from the instruction table.
    function automatic logic [11:0] exp_ctrl(input logic [8:0] code);
        int r_alu [8] = '{0, 1, 2, 3, 4, 5, 0, 1};
        int grp = int'(code[8:7]);
        int sub = int'(code[6:4]);
        int it = 0, br = 0, mr = 0, mw = 0, src = 1, rw = 0, m2r = 0, op = 0;
        case (grp)
            1: begin it = 3; rw = 1; end
            2: begin it = 2; mr = 1; m2r = 1; rw = 1; src = 0; op = 0; end
            3: begin it = 2; mw = 1; src = 0; op = 0; end
            default: begin
                op  = r_alu[sub];
                src = (sub == 6) ? 0 : 1;
                br  = (sub == 7) ? 1 : 0;
                rw  = (sub == 7) ? 0 : 1;
            end
        endcase
        return {2'(it), 1'(br), 1'(mr), 1'(mw), 1'(src), 1'(rw), 1'(m2r), 4'(op)};
    endfunction

    function automatic int model_next(input logic [8:0] code, input logic cond);
        int k = int'(code[3:0]);
        int v;
        bit is_br = (code[8:7] == 2'b00) && (code[6:4] == 3'b111);
        if (model_pc == 50) return 50;
        if (is_br && cond) begin
`ifdef REL_JUMP_EN
            if (k >= 8) begin
                v = k & 7;
                if (v >= 4) v = v - 8;
                return (model_pc + v + 4096) % 4096;
            end
`endif
            return 4 * k;
        end
        return (model_pc + 1) % 4096;
    endfunction

    // ---------------- driver ----------------
    // Called just after a rising edge: drive, check decode, clock once, check PC.
    task automatic apply(input logic [8:0] code, input logic cond);
        int nxt;
        mach_code   = code;
        branch_cond = cond;
        #1;
        check("ctrl", {20'd0, InstType, BranchInst, MemRead, MemWrite, ALUSrc,
                       RegWrite, MemtoReg, ALUOp}, {20'd0, exp_ctrl(code)});
        check("target", {20'd0, target}, 4 * int'(code[3:0]));
        check("done_pre", {31'd0, done}, (model_pc == 50) ? 1 : 0);
        nxt = model_next(code, cond);
        @(posedge clk);
        #1;
        model_pc = nxt;
        check("pc", {20'd0, prog_ctr}, model_pc);
        check("done", {31'd0, done}, (model_pc == 50) ? 1 : 0);
    endtask

    task automatic async_reset_pulse();
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_pc", {20'd0, prog_ctr}, 0);
        check("async_rst_done", {31'd0, done}, 0);
        @(posedge clk);
        #1;
        check("rst_hold_pc", {20'd0, prog_ctr}, 0);
        reset = 1'b1;
        model_pc = 0;
    endtask

    localparam logic [8:0] OP_ADD = 9'b0_0000_0110;

    // ---------------- directed + random sequence ----------------
    initial begin
        int guard;
        logic [8:0] code;

        reset       = 1'b0;
        mach_code   = 9'b1_0000_0010;   // LB, decoded even in reset
        branch_cond = 1'b1;

        // Reset held with clock running
        repeat (3) @(posedge clk);
        #1;
        check("reset_pc", {20'd0, prog_ctr}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_decode_lb", {20'd0, InstType, BranchInst, MemRead, MemWrite,
              ALUSrc, RegWrite, MemtoReg, ALUOp}, {20'd0, exp_ctrl(9'b1_0000_0010)});
        reset    = 1'b1;
        model_pc = 0;

        // Three ADDs after release
        repeat (3) apply(OP_ADD, 1'b0);
        check("pc_after_3", {20'd0, prog_ctr}, 3);

        // Decode sweep: every group and R sub-op, random low bits, no branches taken
        for (int g = 0; g < 4; g++) begin
            for (int s = 0; s < 8; s++) begin
                code = {2'(g), 3'(s), 4'($urandom_range(0, 15))};
                apply(code, 1'b0);
            end
        end
        apply(9'b0_1011_0101, 1'b1);   // MOVI
        check("movi_insttype", {30'd0, InstType}, 3);

        // Taken branch then fall-through
        apply(9'b0_0111_0101, 1'b1);
        check("taken_pc", {20'd0, prog_ctr}, 20);
        apply(9'b0_0111_0101, 1'b0);
        check("not_taken_pc", {20'd0, prog_ctr}, 21);

        // Async reset mid-run from PC 20
        apply(9'b0_0111_0101, 1'b1);
        check("pre_reset_pc", {20'd0, prog_ctr}, 20);
        async_reset_pulse();

        // Run to halt, then taken branches must not move the PC
        guard = 0;
        while (model_pc != 50 && guard < 200) begin
            apply(OP_ADD, 1'b0);
            guard++;
        end
        check("halt_reached", {20'd0, prog_ctr}, 50);
        repeat (5) apply(9'b0_0111_0101, 1'b1);
        check("halt_hold_pc", {20'd0, prog_ctr}, 50);
        check("halt_done", {31'd0, done}, 1);

        // Relative / table branch from PC 10
        async_reset_pulse();
        repeat (10) apply(OP_ADD, 1'b0);
        apply(9'b0_0111_1110, 1'b1);
`ifdef REL_JUMP_EN
        check("rel_jump_pc", {20'd0, prog_ctr}, 8);
`else
        check("lut_jump_pc", {20'd0, prog_ctr}, 56);
`endif

`ifndef REL_JUMP_EN
        // Wrap from 4095 to 0: jump to 60, then increment all the way round
        async_reset_pulse();
        apply(9'b0_0111_1111, 1'b1);
        guard = 0;
        while (model_pc != 0 && guard < 5000) begin
            apply(9'b0_0000_0000, 1'b0);
            guard++;
        end
        check("wrap_pc", {20'd0, prog_ctr}, 0);
`endif

        // Randomized run with random branch conditions
        async_reset_pulse();
        for (int i = 0; i < 80; i++) begin
            code = 9'($urandom_range(0, 511));
            if (($urandom_range(0, 3)) == 0) code[8:4] = 5'b00111;  // bias toward BR
            apply(code, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
